// File: rtl/operand_stack.sv
// rtl/operand_stack.sv - operand stack with top/penultimate registers over a spill array
module operand_stack #(
    parameter int W = 8,
    parameter int D = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   op,
    input  logic [W-1:0] push_data,
    input  logic         err_clr,
    output logic [W-1:0] top_val,
    output logic [W-1:0] pen_val,
    output logic [D:0]   depth,
    output logic         empty,
    output logic         full,
    output logic         ovf,
    output logic         unf
);

    localparam int CAP     = 2 ** D;
    localparam int SPILL_N = CAP - 2;
    localparam int SW      = (SPILL_N > 1) ? $clog2(SPILL_N) : 1;

    localparam logic [D:0] CAP_V = {1'b1, {D{1'b0}}};
    localparam logic [D:0] ONE   = (D+1)'(1);
    localparam logic [D:0] TWO   = (D+1)'(2);
    localparam logic [D:0] THREE = (D+1)'(3);
    localparam logic [D:0] FOUR  = (D+1)'(4);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_PUSH  = 3'd1;
    localparam logic [2:0] OP_POP   = 3'd2;
    localparam logic [2:0] OP_POP2  = 3'd3;
    localparam logic [2:0] OP_DUP   = 3'd4;
    localparam logic [2:0] OP_SWAP  = 3'd5;
    localparam logic [2:0] OP_REPL  = 3'd6;
    localparam logic [2:0] OP_BINOP = 3'd7;

    logic [W-1:0] top_q, top_d;
    logic [W-1:0] pen_q, pen_d;
    logic [D:0]   depth_q, depth_d;
    logic         empty_q, empty_d;
    logic         full_q, full_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;

    // Spill array holds entries below the penultimate; it carries no reset.
    logic [W-1:0] spill_mem [SPILL_N];

    logic         spill_we;
    logic [SW-1:0] spill_waddr;
    logic [SW-1:0] idx3, idx4;
    logic [D:0]   n_m2, n_m3, n_m4;
    logic [W-1:0] rd3, rd4;
    logic         ovf_err, unf_err;

    // Spill addresses and the two read ports, gated to zero when the slot is not valid.
    always_comb begin
        n_m2        = depth_q - TWO;
        n_m3        = depth_q - THREE;
        n_m4        = depth_q - FOUR;
        spill_waddr = n_m2[SW-1:0];
        idx3        = n_m3[SW-1:0];
        idx4        = n_m4[SW-1:0];
        rd3         = (depth_q >= THREE) ? spill_mem[idx3] : '0;
        rd4         = (depth_q >= FOUR)  ? spill_mem[idx4] : '0;
    end

    // Legality of the requested op against the current depth.
    always_comb begin
        ovf_err = ((op == OP_PUSH) || (op == OP_DUP)) && (depth_q == CAP_V);
        unf_err = (((op == OP_POP) || (op == OP_DUP) || (op == OP_REPL)) && (depth_q < ONE)) ||
                  (((op == OP_POP2) || (op == OP_SWAP) || (op == OP_BINOP)) && (depth_q < TWO));
    end

    // Next-state datapath; illegal ops leave everything untouched except the flags.
    always_comb begin
        top_d    = top_q;
        pen_d    = pen_q;
        depth_d  = depth_q;
        spill_we = 1'b0;
        ovf_d    = (ovf_q & ~err_clr) | ovf_err;
        unf_d    = (unf_q & ~err_clr) | unf_err;
        if (!ovf_err && !unf_err) begin
            case (op)
                OP_PUSH: begin
                    spill_we = (depth_q >= TWO);
                    pen_d    = top_q;
                    top_d    = push_data;
                    depth_d  = depth_q + ONE;
                end
                OP_POP: begin
                    top_d   = pen_q;
                    pen_d   = rd3;
                    depth_d = depth_q - ONE;
                end
                OP_POP2: begin
                    top_d   = rd3;
                    pen_d   = rd4;
                    depth_d = depth_q - TWO;
                end
                OP_DUP: begin
                    spill_we = (depth_q >= TWO);
                    pen_d    = top_q;
                    depth_d  = depth_q + ONE;
                end
                OP_SWAP: begin
                    top_d = pen_q;
                    pen_d = top_q;
                end
                OP_REPL: begin
                    top_d = push_data;
                end
                OP_BINOP: begin
                    top_d   = push_data;
                    pen_d   = rd3;
                    depth_d = depth_q - ONE;
                end
                OP_NOP: begin
                end
                default: begin
                end
            endcase
        end
        empty_d = (depth_d == '0);
        full_d  = (depth_d == CAP_V);
    end

    // Cached top/penultimate, depth, status and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_q   <= '0;
            pen_q   <= '0;
            depth_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            top_q   <= top_d;
            pen_q   <= pen_d;
            depth_q <= depth_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Single write port: the outgoing penultimate spills on PUSH/DUP at depth >= 2.
    always_ff @(posedge clk) begin
        if (spill_we && !reset) begin
            spill_mem[spill_waddr] <= pen_q;
        end
    end

    assign top_val = top_q;
    assign pen_val = pen_q;
    assign depth   = depth_q;
    assign empty   = empty_q;
    assign full    = full_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;

endmodule
